bcd_display_mux: RTL and testbench

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

---
 rtl/bcd_disp_pkg.sv | 35 +++
 rtl/bcd_display_mux_if.sv | 28 ++
 rtl/bcd_to_7seg.sv | 19 +
 rtl/bcd_display_mux.sv | 105 ++++++++++
 tb/tb_bcd_display_mux.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg
// Shared constants and types for the BCD display multiplexer:
//   slot_t      2-bit digit slot index (0 = least-significant digit)
//   SEG_TABLE   active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
//   SEG_DASH    pattern shown for invalid digits 10..15
//   SEG_BLANK   all segments off
//   AN_OFF      all digit enables off
//   an_for_slot active-low one-cold digit enable for a slot
package bcd_disp_pkg;

  typedef logic [1:0] slot_t;

  // Index 9 is the leftmost element, index 0 the rightmost.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic [3:0] an_for_slot(input slot_t s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// bcd_display_mux_if
// Bundles the data-side signals of the display multiplexer.
//   load         one-cycle strobe capturing BCD_0..BCD_3
//   BCD_0..BCD_3 BCD digits, BCD_0 least significant
//   seg          active-low segment drive {g,f,e,d,c,b,a}
//   an           active-low digit enables, an[i] selects digit i
// master: the side supplying digits; slave: the multiplexer itself.
interface bcd_display_mux_if;

  logic       load;
  logic [3:0] BCD_0;
  logic [3:0] BCD_1;
  logic [3:0] BCD_2;
  logic [3:0] BCD_3;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output load, BCD_0, BCD_1, BCD_2, BCD_3,
    input  seg, an
  );

  modport slave (
    input  load, BCD_0, BCD_1, BCD_2, BCD_3,
    output seg, an
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg
// Purely combinational 4-bit BCD to active-low 7-segment decoder.
//   digit  input  4  BCD value
//   seg    output 7  {g,f,e,d,c,b,a}, active-low; values 10..15 give a dash
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux
// Time-multiplexed driver for a four-digit common-anode 7-segment display.
// Four BCD digits are captured on a load strobe; a prescaler steps a slot
// index through digits 0..3, and the registered seg/an outputs show one
// digit per slot, with optional leading-zero blanking.
//   clk    input   system clock
//   rst_n  input   asynchronous active-low reset
//   bus    slave   load, BCD_0..BCD_3 in; seg, an out (see bcd_display_mux_if)
// Parameters:
//   PRESCALE  clock cycles per digit slot (2..65535)
//   BLANK_EN  1 = blank leading zeros in digits 3..1
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_display_mux_if.slave   bus
);

  localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

  logic [3:0][3:0] digits;
  logic [15:0]     count;
  logic            tick;
  slot_t           slot;
  logic [3:0]      zero;
  logic [3:0]      blank_mask;
  logic            slot_blank;
  logic [3:0]      cur_digit;
  logic [6:0]      dec_seg;
  logic [6:0]      seg_q;
  logic [3:0]      an_q;

  // Digit storage; a load coinciding with a tick is still captured, so the
  // slot entered on that edge is displayed with the new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
    end else if (bus.load) begin
      digits <= {bus.BCD_3, bus.BCD_2, bus.BCD_1, bus.BCD_0};
    end
  end

  assign tick = (count == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  // Slot index wraps naturally at 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (tick) begin
      slot <= slot + 2'd1;
    end
  end

  // Leading-zero blanking: a digit is blank only if it and every more
  // significant digit are exactly zero. Codes 10..15 are not zero, so
  // they stop blanking and show a dash.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      zero[i] = (digits[i] == 4'd0);
    end
    blank_mask    = '0;
    blank_mask[3] = zero[3];
    blank_mask[2] = zero[3] & zero[2];
    blank_mask[1] = zero[3] & zero[2] & zero[1];
  end

  assign slot_blank = BLANK_EN & blank_mask[slot];
  assign cur_digit  = digits[slot];

  bcd_to_7seg u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else if (slot_blank) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= dec_seg;
      an_q  <= an_for_slot(slot);
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux
// Drives two multiplexers (BLANK_EN=1 and BLANK_EN=0, PRESCALE=4) with the
// same loads. Expected {an,seg} values are hand-computed and queued with the
// output cycle they belong to; a negedge monitor pops and compares them.
// Output cycle c = number of rising edges since reset release; with
// PRESCALE=4 cycle c shows slot ((c-1)/4) mod 4.
module tb_bcd_display_mux;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S6    = 7'b0000010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SOFF  = 7'b1111111;
  localparam logic [3:0] AOFF  = 4'b1111;

  typedef struct {
    int         c;
    bit         sel;   // 0 = blanking DUT, 1 = non-blanking DUT
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_count;
  int   checks;
  int   fails;
  exp_t sb[$];
  exp_t mon_e;

  bcd_display_mux_if bus_b ();
  bcd_display_mux_if bus_n ();

  bcd_display_mux #(.PRESCALE(4), .BLANK_EN(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  bcd_display_mux #(.PRESCALE(4), .BLANK_EN(1'b0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_count <= 0;
    else        edge_count <= edge_count + 1;
  end

  function automatic void checkOutput(input string name, input int c, input int sel,
                                      input logic [3:0] an_act, input logic [3:0] an_exp,
                                      input logic [6:0] seg_act, input logic [6:0] seg_exp);
    checks++;
    if (an_act !== an_exp || seg_act !== seg_exp) begin
      fails++;
      $display("[TB] FAIL %s c=%0d dut=%0d: an=%b seg=%b, required an=%b seg=%b",
               name, c, sel, an_act, seg_act, an_exp, seg_exp);
    end
  endfunction

  function automatic void push_exp(input int c, input bit sel,
                                   input logic [3:0] an, input logic [6:0] seg);
    exp_t e;
    e.c = c; e.sel = sel; e.an = an; e.seg = seg;
    sb.push_back(e);
  endfunction

  function automatic void push_both(input int c, input logic [3:0] an, input logic [6:0] seg);
    push_exp(c, 1'b0, an, seg);
    push_exp(c, 1'b1, an, seg);
  endfunction

  // Monitor: compare every queued entry whose cycle has arrived.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].c <= edge_count) begin
        mon_e = sb.pop_front();
        if (mon_e.c < edge_count) begin
          checks++;
          fails++;
          $display("[TB] FAIL missed c=%0d dut=%0d: seen at c=%0d, required at c=%0d",
                   mon_e.c, mon_e.sel, edge_count, mon_e.c);
        end else if (mon_e.sel) begin
          checkOutput("scan", mon_e.c, 1, bus_n.an, mon_e.an, bus_n.seg, mon_e.seg);
        end else begin
          checkOutput("scan", mon_e.c, 0, bus_b.an, mon_e.an, bus_b.seg, mon_e.seg);
        end
      end
    end
  end

  task automatic wait_count(input int c);
    int guard = 0;
    while (edge_count < c && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      fails++;
      $display("[TB] FAIL wait_count: edge_count=%0d, required %0d", edge_count, c);
    end
  endtask

  // Called on a negedge; the digits are captured on the following rising edge.
  task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2,
                               input logic [3:0] d1, input logic [3:0] d0);
    bus_b.load = 1'b1; bus_n.load = 1'b1;
    bus_b.BCD_3 = d3; bus_b.BCD_2 = d2; bus_b.BCD_1 = d1; bus_b.BCD_0 = d0;
    bus_n.BCD_3 = d3; bus_n.BCD_2 = d2; bus_n.BCD_1 = d1; bus_n.BCD_0 = d0;
    @(negedge clk);
    bus_b.load = 1'b0; bus_n.load = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus_b.load = 1'b0; bus_n.load = 1'b0;
    bus_b.BCD_0 = '0; bus_b.BCD_1 = '0; bus_b.BCD_2 = '0; bus_b.BCD_3 = '0;
    bus_n.BCD_0 = '0; bus_n.BCD_1 = '0; bus_n.BCD_2 = '0; bus_n.BCD_3 = '0;

    // Outputs during reset.
    #12;
    checkOutput("reset", 0, 0, bus_b.an, AOFF, bus_b.seg, SOFF);
    checkOutput("reset", 0, 1, bus_n.an, AOFF, bus_n.seg, SOFF);

    // Scan after release with all digits zero.
    push_both(1, 4'b1110, S0);
    push_both(4, 4'b1110, S0);
    push_exp(5, 1'b0, AOFF, SOFF);
    push_exp(5, 1'b1, 4'b1101, S0);
    push_exp(9, 1'b0, AOFF, SOFF);
    push_exp(9, 1'b1, 4'b1011, S0);
    push_exp(13, 1'b0, AOFF, SOFF);
    push_exp(13, 1'b1, 4'b0111, S0);
    @(negedge clk);
    rst_n = 1'b1;

    // Digits 4,0,9,5 loaded mid slot 0: seg changes one cycle after capture.
    wait_count(16);
    push_both(17, 4'b1110, S0);
    push_both(18, 4'b1110, S5);
    push_both(21, 4'b1101, S9);
    push_both(25, 4'b1011, S0);
    push_both(29, 4'b0111, S4);
    applyStimulus(4'd4, 4'd0, 4'd9, 4'd5);

    // Digits 0,0,0,7: leading zeros blanked only on the blanking DUT.
    wait_count(32);
    push_both(33, 4'b1110, S5);
    push_both(34, 4'b1110, S7);
    push_exp(37, 1'b0, AOFF, SOFF);
    push_exp(37, 1'b1, 4'b1101, S0);
    push_exp(41, 1'b0, AOFF, SOFF);
    push_exp(41, 1'b1, 4'b1011, S0);
    push_exp(45, 1'b0, AOFF, SOFF);
    push_exp(45, 1'b1, 4'b0111, S0);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd7);

    // Digit 1 = 12: dash, never blanked.
    wait_count(48);
    push_both(50, 4'b1110, S0);
    push_both(53, 4'b1101, SDASH);
    push_exp(57, 1'b0, AOFF, SOFF);
    push_exp(57, 1'b1, 4'b1011, S0);
    push_exp(61, 1'b0, AOFF, SOFF);
    push_exp(61, 1'b1, 4'b0111, S0);
    applyStimulus(4'd0, 4'd0, 4'd12, 4'd0);

    // Load captured on the slot 0 -> 1 tick edge (edge 68).
    wait_count(67);
    push_both(68, 4'b1110, S0);
    push_both(69, 4'b1101, S6);
    push_exp(73, 1'b0, AOFF, SOFF);
    push_exp(73, 1'b1, 4'b1011, S0);
    applyStimulus(4'd0, 4'd0, 4'd6, 4'd8);

    // Asynchronous reset in the middle of slot 2.
    wait_count(74);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 74, 0, bus_b.an, AOFF, bus_b.seg, SOFF);
    checkOutput("async_reset", 74, 1, bus_n.an, AOFF, bus_n.seg, SOFF);
    @(negedge clk);
    @(negedge clk);
    push_both(1, 4'b1110, S0);
    push_both(2, 4'b1110, S0);
    push_exp(5, 1'b0, AOFF, SOFF);
    push_exp(5, 1'b1, 4'b1101, S0);
    rst_n = 1'b1;

    wait_count(8);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      fails++;
      $display("[TB] FAIL unchecked c=%0d dut=%0d: never compared, required an=%b seg=%b",
               mon_e.c, mon_e.sel, mon_e.an, mon_e.seg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
